// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and width helpers for the write-back port arbiter.
// The register file exposes a fixed number of write ports.
package wb_port_arbiter_pkg;

  localparam int WB_PORTS = 4;

  // Width of a physical register tag; a single-entry file still gets one bit.
  function automatic int tag_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_select.sv
// Combinational round-robin selection of up to WB_PORTS occupied slots.
// Scanning starts at rr_ptr. A slot whose tag matches an earlier grant is skipped.
module wb_rr_select
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 6,
  parameter int TW      = 6,
  parameter int IW      = 3
) (
  input  logic [NUM_REQ-1:0]              occ,
  input  logic [NUM_REQ*TW-1:0]           tags,
  input  logic [IW-1:0]                   rr_ptr,
  output logic [NUM_REQ-1:0]              grant,
  output logic [WB_PORTS-1:0][IW-1:0]     port_idx,
  output logic [WB_PORTS-1:0]             port_vld,
  output logic [IW-1:0]                   last_idx
);

  logic [IW:0]                    pos;
  logic [IW-1:0]                  cand;
  logic [2:0]                     cnt;
  logic                           dup;
  logic [WB_PORTS-1:0][TW-1:0]    ptag;

  always_comb begin
    grant    = '0;
    port_idx = '0;
    port_vld = '0;
    last_idx = rr_ptr;
    ptag     = '0;
    cnt      = '0;
    pos      = '0;
    cand     = '0;
    dup      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NUM_REQ)) pos = pos - (IW+1)'(NUM_REQ);
      cand = pos[IW-1:0];
      // Two writes to one register on the same edge would race in the file.
      dup = 1'b0;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (port_vld[p] && (ptag[p] == tags[cand*TW +: TW])) dup = 1'b1;
      end
      if (occ[cand] && !dup && (cnt < 3'(WB_PORTS))) begin
        grant[cand]         = 1'b1;
        port_idx[cnt[1:0]]  = cand;
        ptag[cnt[1:0]]      = tags[cand*TW +: TW];
        port_vld[cnt[1:0]]  = 1'b1;
        last_idx            = cand;
        cnt                 = cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: one holding slot per result producer, up to four
// registered register-file writes per cycle in round-robin order.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int NUM_REQ = 6,
  localparam int TW     = tag_width(DEPTH),
  localparam int IW     = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TW-1:0]    req_tag,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     we_1,
  output logic                     we_2,
  output logic                     we_3,
  output logic                     we_4,
  output logic [TW-1:0]            write_reg1,
  output logic [TW-1:0]            write_reg2,
  output logic [TW-1:0]            write_reg3,
  output logic [TW-1:0]            write_reg4,
  output logic [WIDTH-1:0]         write_reg1_data,
  output logic [WIDTH-1:0]         write_reg2_data,
  output logic [WIDTH-1:0]         write_reg3_data,
  output logic [WIDTH-1:0]         write_reg4_data,
  output logic                     wb_busy
);

  logic [NUM_REQ-1:0]               slot_v;
  logic [NUM_REQ-1:0][TW-1:0]       slot_tag;
  logic [NUM_REQ-1:0][WIDTH-1:0]    slot_data;
  logic [IW-1:0]                    rr_ptr;

  logic [NUM_REQ-1:0]               grant;
  logic [WB_PORTS-1:0][IW-1:0]      port_idx;
  logic [WB_PORTS-1:0]              port_vld;
  logic [IW-1:0]                    last_idx;
  logic [IW-1:0]                    next_ptr;
  logic [NUM_REQ-1:0]               accept;

  logic [WB_PORTS-1:0]              port_we;
  logic [WB_PORTS-1:0][TW-1:0]      sel_tag;
  logic [WB_PORTS-1:0][WIDTH-1:0]   sel_data;

  logic [WB_PORTS-1:0]              we_p1;
  logic [WB_PORTS-1:0][TW-1:0]      tag_p1;
  logic [WB_PORTS-1:0][WIDTH-1:0]   data_p1;

  wb_rr_select #(
    .NUM_REQ (NUM_REQ),
    .TW      (TW),
    .IW      (IW)
  ) u_select (
    .occ      (slot_v),
    .tags     (slot_tag),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .port_idx (port_idx),
    .port_vld (port_vld),
    .last_idx (last_idx)
  );

  // A slot draining this cycle can take a new result on the same edge.
  assign req_ready = {NUM_REQ{!flush}} & (~slot_v | grant);
  assign accept    = req_valid & req_ready;
  assign wb_busy   = |slot_v;
  assign next_ptr  = (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + IW'(1);

  always_comb begin
    port_we  = '0;
    sel_tag  = '0;
    sel_data = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (port_vld[p]) begin
        sel_tag[p] = slot_tag[port_idx[p]];
        port_we[p] = (slot_tag[port_idx[p]] != '0);
        if (port_we[p]) sel_data[p] = slot_data[port_idx[p]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      slot_v <= '0;
    end else begin
      slot_v <= (slot_v & ~grant) | accept;
      if (|grant) rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slot_tag[i]  <= req_tag[i*TW +: TW];
        slot_data[i] <= req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Stage p1: registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p1   <= '0;
      tag_p1  <= '0;
      data_p1 <= '0;
    end else if (flush) begin
      we_p1   <= '0;
      tag_p1  <= '0;
      data_p1 <= '0;
    end else begin
      we_p1   <= port_we;
      tag_p1  <= sel_tag;
      data_p1 <= sel_data;
    end
  end

  assign we_1            = we_p1[0];
  assign we_2            = we_p1[1];
  assign we_3            = we_p1[2];
  assign we_4            = we_p1[3];
  assign write_reg1      = tag_p1[0];
  assign write_reg2      = tag_p1[1];
  assign write_reg3      = tag_p1[2];
  assign write_reg4      = tag_p1[3];
  assign write_reg1_data = data_p1[0];
  assign write_reg2_data = data_p1[1];
  assign write_reg3_data = data_p1[2];
  assign write_reg4_data = data_p1[3];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a slot/queue model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 64;
  localparam int NUM_REQ = 6;
  localparam int TW      = 6;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     flush = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*TW-1:0]    req_tag = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     we_1, we_2, we_3, we_4;
  logic [TW-1:0]            write_reg1, write_reg2, write_reg3, write_reg4;
  logic [WIDTH-1:0]         write_reg1_data, write_reg2_data, write_reg3_data, write_reg4_data;
  logic                     wb_busy;

  always #5 clk = ~clk;

  wb_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .we_1(we_1), .we_2(we_2), .we_3(we_3), .we_4(we_4),
    .write_reg1(write_reg1), .write_reg2(write_reg2), .write_reg3(write_reg3), .write_reg4(write_reg4),
    .write_reg1_data(write_reg1_data), .write_reg2_data(write_reg2_data),
    .write_reg3_data(write_reg3_data), .write_reg4_data(write_reg4_data),
    .wb_busy(wb_busy)
  );

  logic             d_we[4];
  logic [TW-1:0]    d_tag[4];
  logic [WIDTH-1:0] d_data[4];
  assign d_we[0] = we_1;  assign d_we[1] = we_2;  assign d_we[2] = we_3;  assign d_we[3] = we_4;
  assign d_tag[0] = write_reg1;  assign d_tag[1] = write_reg2;
  assign d_tag[2] = write_reg3;  assign d_tag[3] = write_reg4;
  assign d_data[0] = write_reg1_data;  assign d_data[1] = write_reg2_data;
  assign d_data[2] = write_reg3_data;  assign d_data[3] = write_reg4_data;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot contents, pointer, and what each port must show.
  bit               m_v[NUM_REQ];
  logic [TW-1:0]    m_tag[NUM_REQ];
  logic [WIDTH-1:0] m_data[NUM_REQ];
  int               m_ptr;
  bit               m_g[NUM_REQ];
  int               m_pl[4];
  int               m_np;
  logic             e_we[4];
  logic [TW-1:0]    e_tag[4];
  logic [WIDTH-1:0] e_data[4];

  task automatic m_clear();
    for (int i = 0; i < NUM_REQ; i++) m_v[i] = 0;
    m_ptr = 0;
    for (int p = 0; p < 4; p++) begin e_we[p] = 0; e_tag[p] = '0; e_data[p] = '0; end
  endtask

  task automatic m_arb();
    int i;
    bit dup;
    m_np = 0;
    for (int k = 0; k < NUM_REQ; k++) m_g[k] = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (m_ptr + k) % NUM_REQ;
      if (m_v[i] && m_np < 4) begin
        dup = 0;
        for (int p = 0; p < m_np; p++) if (m_tag[m_pl[p]] == m_tag[i]) dup = 1;
        if (!dup) begin m_pl[m_np] = i; m_np++; m_g[i] = 1; end
      end
    end
  endtask

  task automatic m_step();
    bit rdy[NUM_REQ];
    int i;
    m_arb();
    if (flush) begin
      for (int k = 0; k < NUM_REQ; k++) m_v[k] = 0;
      for (int p = 0; p < 4; p++) begin e_we[p] = 0; e_tag[p] = '0; e_data[p] = '0; end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (p < m_np) begin
          i = m_pl[p];
          e_we[p]   = (m_tag[i] != 0);
          e_tag[p]  = m_tag[i];
          e_data[p] = e_we[p] ? m_data[i] : '0;
        end else begin
          e_we[p] = 0; e_tag[p] = '0; e_data[p] = '0;
        end
      end
      for (int k = 0; k < NUM_REQ; k++) rdy[k] = !m_v[k] || m_g[k];
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_valid[k] && rdy[k]) begin
          m_v[k] = 1; m_tag[k] = req_tag[k*TW +: TW]; m_data[k] = req_data[k*WIDTH +: WIDTH];
        end else if (m_g[k]) begin
          m_v[k] = 0;
        end
      end
      if (m_np > 0) m_ptr = (m_pl[m_np-1] + 1) % NUM_REQ;
    end
  endtask

  task automatic check_out();
    bit busy;
    busy = 0;
    for (int k = 0; k < NUM_REQ; k++) busy |= m_v[k];
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("we_%0d", p+1), 64'(d_we[p]), 64'(e_we[p]));
      chk($sformatf("write_reg%0d", p+1), 64'(d_tag[p]), 64'(e_tag[p]));
      chk($sformatf("write_reg%0d_data", p+1), 64'(d_data[p]), 64'(e_data[p]));
    end
    chk("wb_busy", 64'(wb_busy), 64'(busy));
  endtask

  task automatic check_ready();
    m_arb();
    for (int k = 0; k < NUM_REQ; k++)
      chk($sformatf("req_ready[%0d]", k), 64'(req_ready[k]), 64'(!flush && (!m_v[k] || m_g[k])));
  endtask

  // Entered and left at one time unit after a rising edge.
  task automatic cyc();
    #1 check_ready();
    @(posedge clk);
    if (rst_n) m_step();
    #1 check_out();
  endtask

  task automatic clear_in();
    req_valid = '0; req_tag = '0; req_data = '0; flush = 1'b0;
  endtask

  task automatic set_req(input int u, input int tag, input logic [WIDTH-1:0] data);
    req_valid[u] = 1'b1;
    req_tag[u*TW +: TW] = TW'(tag);
    req_data[u*WIDTH +: WIDTH] = data;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    clear_in();
    #1;
    chk("rst_we_any", 64'({we_1, we_2, we_3, we_4}), 64'h0);
    chk("rst_tags", 64'({write_reg1, write_reg2, write_reg3, write_reg4}), 64'h0);
    chk("rst_data1", 64'(write_reg1_data), 64'h0);
    chk("rst_busy", 64'(wb_busy), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h3f);
    m_clear();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    m_step();
    #1 check_out();
    chk("post_rst_ready", 64'(req_ready), 64'h3f);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int exp_rr[12] = '{10, 11, 12, 13, 14, 15, 10, 11, 12, 13, 14, 15};

  initial begin
    m_clear();
    @(posedge clk); #1;
    do_reset();

    // Single result, two-edge latency.
    set_req(2, 5, 32'hDEADBEEF);
    cyc(); clear_in();
    cyc();
    chk("t1_we_1", 64'(we_1), 64'h1);
    chk("t1_reg1", 64'(write_reg1), 64'd5);
    chk("t1_data1", 64'(write_reg1_data), 64'hDEADBEEF);
    chk("t1_we_2", 64'(we_2), 64'h0);
    cyc();
    chk("t1_we_1_off", 64'(we_1), 64'h0);

    // All units streaming: round-robin rotation across ports.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int u = 0; u < NUM_REQ; u++) set_req(u, 10 + u, WIDTH'((c << 8) | u));
      cyc();
      if (c > 0) begin
        for (int p = 0; p < 4; p++)
          chk($sformatf("t2_c%0d_port%0d", c, p+1), 64'(d_tag[p]), 64'(exp_rr[(c-1)*4 + p]));
      end
    end
    clear_in();
    for (int c = 0; c < 3; c++) cyc();

    // Duplicate tag: the later unit waits one cycle.
    do_reset();
    set_req(1, 7, 32'h111); set_req(3, 7, 32'h333);
    cyc(); clear_in();
    chk("t3_ready3_low", 64'(req_ready[3]), 64'h0);
    cyc();
    chk("t3_a_reg1", 64'(write_reg1), 64'd7);
    chk("t3_a_data1", 64'(write_reg1_data), 64'h111);
    chk("t3_a_we_2", 64'(we_2), 64'h0);
    cyc();
    chk("t3_b_reg1", 64'(write_reg1), 64'd7);
    chk("t3_b_data1", 64'(write_reg1_data), 64'h333);

    // Tag 0 consumes a port without writing.
    do_reset();
    set_req(0, 0, 32'hABC);
    cyc(); clear_in();
    chk("t4_ready0", 64'(req_ready[0]), 64'h1);
    set_req(0, 9, 32'h99);
    cyc(); clear_in();
    chk("t4_we_1_tag0", 64'(we_1), 64'h0);
    cyc();
    chk("t4_we_1", 64'(we_1), 64'h1);
    chk("t4_reg1", 64'(write_reg1), 64'd9);

    // Flush with a competing request; pointer must stay put.
    do_reset();
    for (int u = 0; u < 5; u++) set_req(u, 20 + u, WIDTH'(u));
    cyc(); clear_in();
    flush = 1'b1; set_req(4, 30, 32'h30);
    #1 chk("t5_ready4", 64'(req_ready[4]), 64'h0);
    cyc(); clear_in();
    chk("t5_we_all", 64'({we_1, we_2, we_3, we_4}), 64'h0);
    chk("t5_busy", 64'(wb_busy), 64'h0);
    for (int u = 0; u < NUM_REQ; u++) set_req(u, 40 + u, WIDTH'(u));
    cyc(); clear_in();
    cyc();
    chk("t5_ptr_kept", 64'(write_reg1), 64'd40);
    cyc(); cyc();

    // Asynchronous reset with ports active.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int u = 0; u < NUM_REQ; u++) set_req(u, 50 + u, WIDTH'(u));
      cyc();
    end
    chk("t6_active", 64'(we_1), 64'h1);
    do_reset();

    // Randomized traffic with frequent tag collisions, tag 0, flushes and resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        for (int u = 0; u < NUM_REQ; u++) begin
          req_valid[u] = ($urandom_range(0, 9) < 6);
          req_tag[u*TW +: TW] = TW'($urandom_range(0, 7));
          req_data[u*WIDTH +: WIDTH] = $urandom;
        end
        flush = ($urandom_range(0, 31) == 0);
        cyc();
      end
    end
    clear_in();
    for (int c = 0; c < 4; c++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
